load_store_unit: RTL and testbench

Multicycle load/store unit between the WaveRV core's execute stage and the word-indexed data memory. It accepts one byte, halfword or word access per request and issues a word address, byte-enables and lane-replicated write data to memory. For loads it waits out the memory read latency, then extracts and sign/zero-extends the addressed bytes. It returns completion to the core through a valid/ready handshake.

---
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multicycle RV32I load/store unit: word-indexed memory, lane enables, load extract.
// Optional misaligned trap enabled by defining LSU_MISALIGNED_TRAP_EN.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_store,
  input  logic [2:0]  request_funct3,
  input  logic [31:0] request_address,
  input  logic [31:0] request_write_data,
  output logic        response_valid,
  input  logic        response_ready,
  output logic [31:0] response_data,
  output logic        response_misaligned,
  output logic [31:0] memory_access_address,
  output logic        memory_store,
  output logic [3:0]  memory_byte_enable,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RESPOND
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        w_mis;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_ext;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && request_valid;

`ifdef LSU_MISALIGNED_TRAP_EN
  logic r_mis;

  assign w_mis = request_funct3[1]
               ? (request_address[1:0] != 2'b00)
               : (request_funct3[0] & request_address[0]);
  assign response_misaligned = r_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_mis <= 1'b0;
    else if (w_accept) r_mis <= w_mis;
  end
`else
  assign w_mis = 1'b0;
  assign response_misaligned = 1'b0;
`endif

  assign response_data = r_rdata;

  // Halfword picked by addr[1], then byte within it by addr[0].
  assign w_half = r_addr[1] ? memory_read_data[31:16]
                            : memory_read_data[15:0];
  assign w_byte = r_addr[0] ? w_half[15:8] : w_half[7:0];

  always_comb begin
    w_ext = memory_read_data;
    w_be  = 4'b1111;
    w_wd  = r_wdata;
    unique case (r_funct3[1:0])
      2'b00: begin
        w_ext = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
        w_be  = 4'b0001 << r_addr[1:0];
        w_wd  = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_ext = {{16{~r_funct3[2] & w_half[15]}}, w_half};
        w_be  = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wd  = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next                = r_state;
    request_ready         = 1'b0;
    response_valid        = 1'b0;
    memory_store          = 1'b0;
    memory_access_address = 32'd0;
    memory_byte_enable    = 4'd0;
    memory_write_data     = 32'd0;
    unique case (r_state)
      S_IDLE: begin
        request_ready = 1'b1;
        if (request_valid) begin
          if (w_mis)              w_next = S_RESPOND;
          else if (request_store) w_next = S_STORE;
          else                    w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        memory_access_address = {2'b00, r_addr[31:2]};
        memory_write_data     = w_wd;
        if (r_cnt == 2'd0) w_next = S_RESPOND;
      end
      S_STORE: begin
        memory_store          = 1'b1;
        memory_access_address = {2'b00, r_addr[31:2]};
        memory_byte_enable    = w_be;
        memory_write_data     = w_wd;
        w_next                = S_RESPOND;
      end
      S_RESPOND: begin
        response_valid = 1'b1;
        if (response_ready) w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_store  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_cnt    <= 2'd0;
      r_rdata  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store  <= request_store;
        r_funct3 <= request_funct3;
        r_addr   <= request_address;
        r_wdata  <= request_write_data;
        r_cnt    <= LAT_M1;
        r_rdata  <= 32'd0;
      end
      if (r_state == S_LOAD) begin
        if (r_cnt == 2'd0) r_rdata <= w_ext;
        else               r_cnt   <= r_cnt - 2'd1;
      end
    end
  end

  // Latched direction is kept for observability of the in-flight request.
  logic w_unused;
  assign w_unused = r_store;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: latency-1 instance plus a latency-3 instance.
// Define LSU_MISALIGNED_TRAP_EN to match a trap-enabled build.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  int          total;
  int          bad;

  logic        a_rv, a_rr, a_st, a_pv, a_pr, a_pm, a_ms;
  logic [2:0]  a_f3;
  logic [31:0] a_ad, a_wd, a_pd, a_ma, a_mw, a_rd;
  logic [3:0]  a_be;

  logic        b_rv, b_rr, b_st, b_pv, b_pr, b_pm, b_ms;
  logic [2:0]  b_f3;
  logic [31:0] b_ad, b_wd, b_pd, b_ma, b_mw, b_rd;
  logic [3:0]  b_be;

  load_store_unit #(.READ_LATENCY(1)) u_a (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .request_valid         (a_rv),
    .request_ready         (a_rr),
    .request_store         (a_st),
    .request_funct3        (a_f3),
    .request_address       (a_ad),
    .request_write_data    (a_wd),
    .response_valid        (a_pv),
    .response_ready        (a_pr),
    .response_data         (a_pd),
    .response_misaligned   (a_pm),
    .memory_access_address (a_ma),
    .memory_store          (a_ms),
    .memory_byte_enable    (a_be),
    .memory_write_data     (a_mw),
    .memory_read_data      (a_rd)
  );

  load_store_unit #(.READ_LATENCY(3)) u_b (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .request_valid         (b_rv),
    .request_ready         (b_rr),
    .request_store         (b_st),
    .request_funct3        (b_f3),
    .request_address       (b_ad),
    .request_write_data    (b_wd),
    .response_valid        (b_pv),
    .response_ready        (b_pr),
    .response_data         (b_pd),
    .response_misaligned   (b_pm),
    .memory_access_address (b_ma),
    .memory_store          (b_ms),
    .memory_byte_enable    (b_be),
    .memory_write_data     (b_mw),
    .memory_read_data      (b_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic st, input logic [2:0] f3,
                       input logic [31:0] ad, input logic [31:0] wd);
    a_rv = 1'b1;
    a_st = st;
    a_f3 = f3;
    a_ad = ad;
    a_wd = wd;
    tick();
    a_rv = 1'b0;
  endtask

  task automatic a_done;
    a_pr = 1'b1;
    tick();
    a_pr = 1'b0;
    chk("a_idle_ready", {31'd0, a_rr}, 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] e_ma, input logic [3:0] e_be,
                          input logic [31:0] e_wd);
    a_req(1'b1, f3, ad, wd);
    chk({tag, "_ms"}, {31'd0, a_ms}, 32'd1);
    chk({tag, "_ma"}, a_ma, e_ma);
    chk({tag, "_be"}, {28'd0, a_be}, {28'd0, e_be});
    chk({tag, "_wd"}, a_mw, e_wd);
    tick();
    chk({tag, "_ms_off"}, {31'd0, a_ms}, 32'd0);
    chk({tag, "_pv"}, {31'd0, a_pv}, 32'd1);
    chk({tag, "_pd"}, a_pd, 32'd0);
    a_done();
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] ad, input logic [31:0] e_ma,
                         input logic [31:0] e_pd);
    a_req(1'b0, f3, ad, 32'hCAFEF00D);
    chk({tag, "_ms"}, {31'd0, a_ms}, 32'd0);
    chk({tag, "_be"}, {28'd0, a_be}, 32'd0);
    chk({tag, "_ma"}, a_ma, e_ma);
    chk({tag, "_pv0"}, {31'd0, a_pv}, 32'd0);
    tick();
    chk({tag, "_pv"}, {31'd0, a_pv}, 32'd1);
    chk({tag, "_pd"}, a_pd, e_pd);
    chk({tag, "_pm"}, {31'd0, a_pm}, 32'd0);
    a_done();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    {a_rv, a_st, a_pr} = '0;
    {b_rv, b_st, b_pr} = '0;
    a_f3 = '0; a_ad = '0; a_wd = '0; a_rd = 32'h80F17F02;
    b_f3 = '0; b_ad = '0; b_wd = '0; b_rd = 32'h0BAD0BAD;
    #12;
    chk("rst_rr", {31'd0, a_rr}, 32'd1);
    chk("rst_pv", {31'd0, a_pv}, 32'd0);
    chk("rst_ms", {31'd0, a_ms}, 32'd0);
    chk("rst_be", {28'd0, a_be}, 32'd0);
    chk("rst_ma", a_ma, 32'd0);
    chk("rst_mw", a_mw, 32'd0);
    chk("rst_pd", a_pd, 32'd0);
    chk("rst_pm", {31'd0, a_pm}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_store("sw", 3'b010, 32'h10, 32'hDEADBEEF, 32'h4, 4'b1111, 32'hDEADBEEF);
    do_store("sb3", 3'b000, 32'h13, 32'h000000A5, 32'h4, 4'b1000, 32'hA5A5A5A5);
    do_store("sh2", 3'b001, 32'h12, 32'h00001234, 32'h4, 4'b1100, 32'h12341234);
    do_store("sb1", 3'b100, 32'h101, 32'hFFFF3377, 32'h40, 4'b0010, 32'h77777777);
    do_store("sh0", 3'b101, 32'h20, 32'hABCD5678, 32'h8, 4'b0011, 32'h56785678);

    a_rd = 32'h80F17F02;
    do_load("lb2", 3'b000, 32'h22, 32'h8, 32'hFFFFFFF1);
    do_load("lbu2", 3'b100, 32'h22, 32'h8, 32'h000000F1);
    do_load("lh2", 3'b001, 32'h22, 32'h8, 32'hFFFF80F1);
    do_load("lhu0", 3'b101, 32'h20, 32'h8, 32'h00007F02);
    do_load("lb1", 3'b000, 32'h21, 32'h8, 32'h0000007F);
    do_load("lb3", 3'b000, 32'h23, 32'h8, 32'hFFFFFF80);
    do_load("lh0", 3'b001, 32'h20, 32'h8, 32'h00007F02);
    do_load("lw", 3'b010, 32'h40, 32'h10, 32'h80F17F02);

`ifdef LSU_MISALIGNED_TRAP_EN
    a_req(1'b0, 3'b010, 32'h6, 32'd0);
    chk("mis_pv", {31'd0, a_pv}, 32'd1);
    chk("mis_pm", {31'd0, a_pm}, 32'd1);
    chk("mis_pd", a_pd, 32'd0);
    chk("mis_ms", {31'd0, a_ms}, 32'd0);
    a_done();
    a_req(1'b1, 3'b001, 32'h5, 32'h1111);
    chk("mis_sh_ms", {31'd0, a_ms}, 32'd0);
    chk("mis_sh_pm", {31'd0, a_pm}, 32'd1);
    a_done();
`else
    do_load("lw6", 3'b010, 32'h6, 32'h1, 32'h80F17F02);
`endif

    // Reset pulsed while a store is in flight.
    a_req(1'b1, 3'b010, 32'h30, 32'h55AA55AA);
    chk("rs_ms_on", {31'd0, a_ms}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_ms_async", {31'd0, a_ms}, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("rs_rr", {31'd0, a_rr}, 32'd1);
    chk("rs_pv", {31'd0, a_pv}, 32'd0);

    // Latency-3 instance: valid data appears only around the sampling edge.
    b_rv = 1'b1;
    b_f3 = 3'b010;
    b_ad = 32'h84;
    tick();
    b_rv = 1'b0;
    chk("b_ma", b_ma, 32'h21);
    chk("b_rr0", {31'd0, b_rr}, 32'd0);
    tick();
    chk("b_pv1", {31'd0, b_pv}, 32'd0);
    b_rd = 32'h13579BDF;
    tick();
    chk("b_pv2", {31'd0, b_pv}, 32'd0);
    tick();
    b_rd = 32'hDEAD0000;
    chk("b_pv3", {31'd0, b_pv}, 32'd1);
    chk("b_pd", b_pd, 32'h13579BDF);
    chk("b_pm", {31'd0, b_pm}, 32'd0);
    b_rv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_hold_pv", {31'd0, b_pv}, 32'd1);
      chk("b_hold_pd", b_pd, 32'h13579BDF);
      chk("b_hold_rr", {31'd0, b_rr}, 32'd0);
      chk("b_hold_ms", {31'd0, b_ms}, 32'd0);
    end
    b_rv = 1'b0;
    b_pr = 1'b1;
    tick();
    b_pr = 1'b0;
    chk("b_done_rr", {31'd0, b_rr}, 32'd1);
    chk("b_done_pv", {31'd0, b_pv}, 32'd0);
    chk("b_idle_be", {28'd0, b_be}, 32'd0);
    chk("b_idle_mw", b_mw, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
